// File: rtl/fifo_ptr_ctrl_if.sv
// Control-side bundle between the FIFO pointer controller and its neighbours:
// producer/consumer handshakes, storage enables/pointers and status.
interface fifo_ptr_ctrl_if #(
    parameter int OSTD_NUM = 8,
    parameter int CNT_SIZE = $clog2(OSTD_NUM + 1)
);
    logic                wr_valid;
    logic                wr_ready;
    logic                rd_ready;
    logic                rd_valid;
    logic                err_clr;
    logic                fifo_wenable;
    logic                fifo_renable;
    logic [OSTD_NUM-1:0] write_ptr;
    logic [OSTD_NUM-1:0] read_ptr;
    logic [CNT_SIZE-1:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                almost_empty;
    logic                overflow_err;
    logic                underflow_err;

    // The environment (producer, consumer, storage, status reader) side.
    modport master (
        output wr_valid, rd_ready, err_clr,
        input  wr_ready, rd_valid, fifo_wenable, fifo_renable,
        input  write_ptr, read_ptr, fifo_count,
        input  fifo_full, fifo_empty, almost_empty, overflow_err, underflow_err
    );

    modport slave (
        input  wr_valid, rd_ready, err_clr,
        output wr_ready, rd_valid, fifo_wenable, fifo_renable,
        output write_ptr, read_ptr, fifo_count,
        output fifo_full, fifo_empty, almost_empty, overflow_err, underflow_err
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/occupancy controller: turns valid/ready handshakes into storage
// enables and wrapping pointers; status is decoded from the occupancy count.
module fifo_ptr_ctrl #(
    parameter int OSTD_NUM        = 8,
    parameter int THRESHOLD_VALUE = OSTD_NUM / 2,
    parameter int PTR_SIZE        = $clog2(OSTD_NUM),
    parameter int CNT_SIZE        = $clog2(OSTD_NUM + 1)
) (
    input logic           clk_in,
    input logic           areset_b,
    fifo_ptr_ctrl_if.slave bus
);
    localparam logic [PTR_SIZE-1:0] LAST_IDX   = PTR_SIZE'(OSTD_NUM - 1);
    localparam logic [CNT_SIZE-1:0] FULL_CNT   = CNT_SIZE'(OSTD_NUM);
    localparam logic [CNT_SIZE-1:0] THRESH_CNT = CNT_SIZE'(THRESHOLD_VALUE);
    localparam logic [CNT_SIZE-1:0] CNT_ONE    = CNT_SIZE'(1);

    logic [PTR_SIZE-1:0] wr_idx_q;
    logic [PTR_SIZE-1:0] rd_idx_q;
    logic [CNT_SIZE-1:0] count_q;
    logic                overflow_q;
    logic                underflow_q;

    logic full;
    logic empty;
    logic wr_fire;
    logic rd_fire;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign wr_fire = bus.wr_valid & ~full;
    assign rd_fire = bus.rd_ready & ~empty;

    assign bus.wr_ready      = ~full;
    assign bus.rd_valid      = ~empty;
    assign bus.fifo_wenable  = wr_fire;
    assign bus.fifo_renable  = rd_fire;
    assign bus.write_ptr     = OSTD_NUM'(wr_idx_q);
    assign bus.read_ptr      = OSTD_NUM'(rd_idx_q);
    assign bus.fifo_count    = count_q;
    assign bus.fifo_full     = full;
    assign bus.fifo_empty    = empty;
    assign bus.almost_empty  = (count_q < THRESH_CNT);
    assign bus.overflow_err  = overflow_q;
    assign bus.underflow_err = underflow_q;

    // Explicit wrap at OSTD_NUM-1 keeps non-power-of-two depths in range.
    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            if (wr_fire) begin
                wr_idx_q <= (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + PTR_SIZE'(1);
            end
            if (rd_fire) begin
                rd_idx_q <= (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + PTR_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            count_q <= '0;
        end else begin
            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (bus.wr_valid & full)  | (overflow_q  & ~bus.err_clr);
            underflow_q <= (bus.rd_ready & empty) | (underflow_q & ~bus.err_clr);
        end
    end

    assert property (@(posedge clk_in) disable iff (!areset_b) count_q <= FULL_CNT);
    assert property (@(posedge clk_in) disable iff (!areset_b)
                     (wr_idx_q <= LAST_IDX) && (rd_idx_q <= LAST_IDX));
endmodule
